// File: rtl/spi_master_mc.sv
// SPI master with per-transfer CPOL/CPHA, clock divider and chip-select selection.
// Define SPI_MASTER_MC_LSB_FIRST_EN to add the lsb_first input for LSB-first transfers.
module spi_master_mc #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned DIV_WIDTH  = 8,
    localparam int unsigned CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  spi_sck,
    output logic [NUM_CS-1:0]     spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int unsigned EW = $clog2(2 * DATA_WIDTH);
    localparam logic [EW-1:0] LastEdge = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StTransfer, StHold, StDone} state_e;

    state_e                state_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [EW-1:0]         edge_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  sck_q;
    logic                  mosi_q;
    logic [NUM_CS-1:0]     cs_n_q;

    logic [NUM_CS-1:0]     cs_dec;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  sample_edge;
    logic                  last_edge;

    // An out-of-range cs_sel matches no line, so the transfer runs with every select high.
    always_comb begin
        cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    logic lsb_q;

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            r[i] = v[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    // The shifter always runs MSB-first; LSB-first is a bit reversal at load and unload.
    assign tx_word = lsb_first ? bit_rev(data_in) : data_in;
    assign rx_word = lsb_q ? bit_rev(rx_q) : rx_q;
`else
    assign tx_word = data_in;
    assign rx_word = rx_q;
`endif

    // Even edge indices are leading edges; CPHA picks leading or trailing for sampling.
    assign sample_edge = ~edge_q[0] ^ cpha_q;
    assign last_edge   = (edge_q == LastEdge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StSetup;
                        cnt_q   <= clk_div;
                        div_q   <= clk_div;
                        edge_q  <= '0;
                        rx_q    <= '0;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        sck_q   <= cpol;
                        busy_q  <= 1'b1;
                        cs_n_q  <= cs_dec;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
                        lsb_q   <= lsb_first;
`endif
                        if (cpha) begin
                            mosi_q <= 1'b0;
                            tx_q   <= tx_word;
                        end else begin
                            mosi_q <= tx_word[DATA_WIDTH-1];
                            tx_q   <= {tx_word[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        state_q <= StTransfer;
                        cnt_q   <= div_q;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                StTransfer: begin
                    if (cnt_q == '0) begin
                        sck_q  <= ~sck_q;
                        cnt_q  <= div_q;
                        edge_q <= edge_q + EW'(1);
                        if (sample_edge) begin
                            rx_q <= {rx_q[DATA_WIDTH-2:0], spi_miso};
                        end else if (!last_edge) begin
                            mosi_q <= tx_q[DATA_WIDTH-1];
                            tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (last_edge) begin
                            state_q <= StHold;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_q    <= StDone;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cs_n_q     <= '1;
                        mosi_q     <= 1'b0;
                        data_out_q <= rx_word;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Randomized self-checking bench for spi_master_mc with a cycle-sampled behavioural SPI slave.
// Define SPI_MASTER_MC_LSB_FIRST_EN to also exercise the lsb_first port.
module tb_spi_master_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic [1:0] cs_sel;
    logic       cpol;
    logic       cpha;
    logic [7:0] clk_div;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    logic       lsb_first;
`endif
    logic       busy;
    logic       done;
    logic [7:0] data_out;
    logic       spi_sck;
    logic [3:0] spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;

    logic       loop_en;
    logic       slave_miso;
    assign spi_miso = loop_en ? spi_mosi : slave_miso;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spi_master_mc #(
        .DATA_WIDTH(8),
        .NUM_CS    (4),
        .DIV_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .cs_sel   (cs_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode: 0 plain, 1 start re-pulsed mid-transfer, 2 start held in the done cycle,
    // 3 reset asserted at the 5th SCK edge. now=1 raises start without waiting a cycle.
    task automatic run_xfer(input logic [7:0] din, input logic [1:0] cs, input logic pol,
                            input logic pha, input logic [7:0] div, input logic [7:0] stx,
                            input bit loop, input int mode, input bit now);
        logic [7:0] s_rx = '0;
        logic [7:0] d0;
        logic [3:0] exp_cs;
        logic       prev_sck;
        bit         prev_act = 0;
        bit         act, leading, samp, got_done = 0, aborted = 0;
        int         s_bi = 0, s_edges = 0, n = 0;
        int         cs_bad = 0, busy_bad = 0, dout_bad = 0, busy_seen = 0;
        exp_cs  = 4'hF;
        exp_cs[cs] = 1'b0;
        loop_en = loop;
        if (!now) @(negedge clk);
        d0       = data_out;
        prev_sck = spi_sck;
        data_in  = din;
        cs_sel   = cs;
        cpol     = pol;
        cpha     = pha;
        clk_div  = div;
        start    = 1'b1;
        while (!got_done && !aborted && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Inputs are don't-care once latched; scramble them.
                start   = 1'b0;
                data_in = 8'($urandom);
                cs_sel  = 2'($urandom);
                cpol    = 1'($urandom);
                cpha    = 1'($urandom);
                clk_div = 8'($urandom);
            end
            if (mode == 1 && n == 10) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end
            if (mode == 1 && n == 11) start = 1'b0;
            act = (spi_cs_n != 4'hF);
            if (act && !prev_act) begin
                s_bi = 0;
                s_rx = '0;
                s_edges = 0;
                prev_sck = spi_sck;
                if (!pha) slave_miso = stx[7];
            end
            if (act && spi_sck != prev_sck) begin
                leading = (s_edges % 2 == 0);
                s_edges++;
                samp = pha ? !leading : leading;
                if (samp) begin
                    s_rx = {s_rx[6:0], spi_mosi};
                end else if (pha) begin
                    slave_miso = stx[7-s_bi];
                    s_bi++;
                end else begin
                    s_bi++;
                    if (s_bi < 8) slave_miso = stx[7-s_bi];
                end
            end
            prev_sck = spi_sck;
            prev_act = act;
            if (done) begin
                got_done = 1;
            end else begin
                if (spi_cs_n !== exp_cs) cs_bad++;
                if (busy !== 1'b1) busy_bad++;
                if (data_out !== d0) dout_bad++;
            end
            if (mode == 3 && s_edges == 5) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_cs_n", 32'(spi_cs_n), 32'hF);
                check_eq("rst_sck", 32'(spi_sck), 32'h0);
                check_eq("rst_busy", 32'(busy), 32'h0);
                check_eq("rst_data_out", 32'(data_out), 32'h0);
                check_eq("rst_mosi", 32'(spi_mosi), 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
            end
        end
        if (mode == 3) begin
            check_eq("rst_reached", 32'(aborted), 32'h1);
            return;
        end
        check_eq("done_seen", 32'(got_done), 32'h1);
        check_eq("done_latency", 32'(n), 32'((2 * 8 + 2) * (int'(div) + 1) + 1));
        check_eq("sck_edges", 32'(s_edges), 32'd16);
        check_eq("sck_idle", 32'(spi_sck), 32'(pol));
        check_eq("cs_pattern", 32'(cs_bad), 32'h0);
        check_eq("busy_during", 32'(busy_bad), 32'h0);
        check_eq("dout_stable", 32'(dout_bad), 32'h0);
        check_eq("busy_in_done", 32'(busy), 32'h0);
        check_eq("cs_in_done", 32'(spi_cs_n), 32'hF);
        check_eq("slave_rx", 32'(s_rx), 32'(din));
        check_eq("data_out", 32'(data_out), 32'(loop ? din : stx));
        if (mode == 2) begin
            start   = 1'b1;
            cs_sel  = 2'd1;
            data_in = 8'h77;
            @(negedge clk);
            start = 1'b0;
            check_eq("done_one_cycle", 32'(done), 32'h0);
            for (int i = 0; i < 3; i++) begin
                if (busy !== 1'b0 || spi_cs_n !== 4'hF) busy_seen++;
                @(negedge clk);
            end
            check_eq("done_start_ignored", 32'(busy_seen), 32'h0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        data_in    = '0;
        cs_sel     = '0;
        cpol       = 1'b0;
        cpha       = 1'b0;
        clk_div    = '0;
        loop_en    = 1'b0;
        slave_miso = 1'b0;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
        lsb_first  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_done", 32'(done), 32'h0);
        check_eq("reset_data_out", 32'(data_out), 32'h0);
        check_eq("reset_sck", 32'(spi_sck), 32'h0);
        check_eq("reset_cs_n", 32'(spi_cs_n), 32'hF);
        check_eq("reset_mosi", 32'(spi_mosi), 32'h0);
        rst_n = 1'b1;

        // Loopback, mode 0, H=2: 37-cycle latency, cs_n=1110.
        run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1, 0, 1'b0);
        // Mode 3 against the slave model.
        run_xfer(8'hC3, 2'd0, 1'b1, 1'b1, 8'd0, 8'h3C, 1'b0, 0, 1'b0);
        // Chip-select routing, with a start held in the done cycle.
        run_xfer(8'h96, 2'd2, 1'b0, 1'b1, 8'd2, 8'h4B, 1'b0, 0, 1'b0);
        run_xfer(8'h3E, 2'd3, 1'b1, 1'b0, 8'd1, 8'hD2, 1'b0, 2, 1'b0);
        run_xfer(8'h81, 2'd0, 1'b0, 1'b0, 8'd0, 8'h7E, 1'b0, 0, 1'b0);
        // Start re-pulsed mid-transfer.
        run_xfer(8'h12, 2'd1, 1'b0, 1'b0, 8'd1, 8'hE7, 1'b0, 1, 1'b0);
        // Reset at the 5th edge, then an immediate restart.
        run_xfer(8'hF0, 2'd2, 1'b1, 1'b0, 8'd1, 8'h55, 1'b0, 3, 1'b0);
        check_eq("post_rst_sck", 32'(spi_sck), 32'h0);
        run_xfer(8'h5A, 2'd1, 1'b0, 1'b1, 8'd1, 8'hA3, 1'b0, 0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            run_xfer(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                     8'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 0, 1'b0);
        end

`ifdef SPI_MASTER_MC_LSB_FIRST_EN
        begin
            int n = 0;
            loop_en = 1'b1;
            @(negedge clk);
            data_in   = 8'h01;
            cs_sel    = 2'd0;
            cpol      = 1'b0;
            cpha      = 1'b0;
            clk_div   = 8'd1;
            lsb_first = 1'b1;
            start     = 1'b1;
            @(negedge clk);
            start     = 1'b0;
            lsb_first = 1'b0;
            check_eq("lsb_first_bit", 32'(spi_mosi), 32'h1);
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
            end
            check_eq("lsb_done", 32'(done), 32'h1);
            check_eq("lsb_data_out", 32'(data_out), 32'h01);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_master_mc.md
SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per transfer (>=2).
REQ-002 SHALL have parameter NUM_CS, default 4: number of chip-select lines (>=1).
REQ-003 SHALL have parameter DIV_WIDTH, default 8: width of clk_div.
REQ-004 SHALL define CSW = max(1, $clog2(NUM_CS)) as the cs_sel width.
REQ-005 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  word to transmit.
REQ-009 SHALL have port cs_sel  input  CSW  target slave index.
REQ-010 SHALL have port cpol  input  1  SCK idle level.
REQ-011 SHALL have port cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-012 SHALL have port clk_div  input  DIV_WIDTH  SCK half-period minus one, in clk cycles.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port data_out  output  DATA_WIDTH  last received word.
REQ-016 SHALL have port spi_sck  output  1  serial clock.
REQ-017 SHALL have port spi_cs_n  output  NUM_CS  active-low chip selects.
REQ-018 SHALL have port spi_mosi  output  1  serial data out.
REQ-019 SHALL have port spi_miso  input  1  serial data in.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, TRANSFER, HOLD, DONE.
REQ-021 SHALL, in IDLE with start=1, latch data_in, cs_sel, cpol, cpha and clk_div, and enter SETUP next cycle; these inputs are don't-care afterwards.
REQ-022 SHALL ignore start in every state except IDLE, including the DONE cycle.
REQ-023 SHALL define H = clk_div+1; SETUP and HOLD each last H cycles, and TRANSFER generates 2*DATA_WIDTH SCK edges spaced H cycles apart.
REQ-024 SHALL drive spi_sck = latched cpol in IDLE, SETUP, HOLD and DONE, with no glitches.
REQ-025 SHALL drive spi_cs_n[cs_sel] low from SETUP entry through HOLD end, all others high; cs_sel >= NUM_CS runs the transfer with all lines high.
REQ-026 SHALL, for cpha=0, present the first bit on spi_mosi at SETUP entry, sample spi_miso on each leading edge, and shift mosi on each trailing edge except the last.
REQ-027 SHALL, for cpha=1, shift mosi on each leading edge (first bit on the first edge) and sample spi_miso on each trailing edge.
REQ-028 SHALL transmit and receive MSB-first (unless REQ-036 applies), and hold spi_mosi at 0 outside SETUP/TRANSFER/HOLD.
REQ-029 SHALL assert busy from the first SETUP cycle through the last HOLD cycle, and deassert it in DONE and IDLE.
REQ-030 SHALL, in DONE (one cycle), drive all spi_cs_n high, pulse done=1, and load data_out with the received word in that same cycle; then return to IDLE.
REQ-031 SHALL assert done exactly (2*DATA_WIDTH+2)*H+1 cycles after the cycle in which start is sampled.
REQ-032 SHALL hold data_out stable except on the done cycle.

Reset
REQ-033 SHALL, on rst_n low, immediately and asynchronously (including mid-transfer) force: state IDLE, busy=0, done=0, data_out=0, spi_sck=0, spi_cs_n=all 1, spi_mosi=0, and clear all counters and shift registers.
REQ-034 SHALL use the reset-time latched cpol=0, and SHALL accept a new start on the first cycle after rst_n rises.

Configuration
REQ-035 SHALL recognise the macro SPI_MASTER_MC_LSB_FIRST_EN.
REQ-036 SHALL, with the macro defined, add input port lsb_first (1 bit), latched with start; when it is 1, both TX and RX are LSB-first and data_out is in natural bit order.
REQ-037 SHALL, with the macro undefined, omit the lsb_first port and operate MSB-first only.

Verification
REQ-038 SHALL verify: DATA_WIDTH=8, cpol=0, cpha=0, clk_div=1, data_in=8'hA5, miso looped to mosi -> data_out=8'hA5, done exactly 37 cycles after start, spi_cs_n=4'b1110 with cs_sel=0.
REQ-039 SHALL verify: cpol=1, cpha=1, clk_div=0, slave model returning 8'h3C, data_in=8'hC3 -> slave sees 8'hC3, data_out=8'h3C, sck idles high, 16 SCK edges.
REQ-040 SHALL verify: cs_sel=2 -> only spi_cs_n[2] low (4'b1011); cs_sel=3 then cs_sel=0 back-to-back -> correct line each time, with start in the DONE cycle ignored.
REQ-041 SHALL verify: start re-pulsed with data_in=8'hFF mid-transfer of 8'h12 -> ignored, slave receives 8'h12.
REQ-042 SHALL verify: rst_n low at the 5th SCK edge -> all spi_cs_n=1, sck=0, busy=0 same cycle, data_out=0; next transfer of 8'h5A completes correctly.
REQ-043 SHALL verify, with SPI_MASTER_MC_LSB_FIRST_EN defined: lsb_first=1, data_in=8'h01 -> first mosi bit 1, loopback data_out=8'h01.
